// File: rtl/rv32i_decode_exec_pkg.sv
// Shared types for the RV32I decode/execute block: ALU modes, write-back source,
// opcode constants, control-FSM states and the per-instruction control bundle.
package rv32i_decode_exec_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_mode_t;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_ALU  = 2'd1,
    DEST_BUS  = 2'd2,
    DEST_PC   = 2'd3
  } dest_reg_from_t;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXECUTE,
    ST_WRITEBACK
  } state_t;

  typedef enum logic {SEL_A_RS1, SEL_A_PC}  alu_a_sel_t;
  typedef enum logic {SEL_B_RS2, SEL_B_IMM} alu_b_sel_t;

  typedef struct packed {
    alu_a_sel_t     alu_in_a;
    alu_b_sel_t     alu_in_b;
    dest_reg_from_t dest_reg_from;
    logic           pc_load;
    logic           branching;
    logic           dbus_re;
    logic           dbus_we;
  } ins_ctrl_signals_t;

  // Register/immediate arithmetic by funct3; alt is only honoured for ADD/SUB and SRL/SRA.
  function automatic alu_mode_t op_mode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    op_mode = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op_mode = ALU_SLL;
      3'd2:    op_mode = ALU_SLT;
      3'd3:    op_mode = ALU_SLTU;
      3'd4:    op_mode = ALU_XOR;
      3'd5:    op_mode = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op_mode = ALU_OR;
      default: op_mode = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decode_exec_if.sv
// Instruction/operand inputs and decode/control outputs of the decode-execute block.
// stall is the bus-wait hold; clk and rst stay outside as plain ports.
interface rv32i_decode_exec_if;

  logic        stall;
  logic [31:0] ir;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] pc;

  logic [6:0]  opcode;
  logic [4:0]  rd_sel;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic [31:0] len;
  logic        illegal;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        branch_taken;
  logic [1:0]  dest_reg_from;
  logic        pc_load;
  logic        dbus_re;
  logic        dbus_we;
  logic        load_ir;
  logic        en_iaddr;
  logic        en_pc_counter;
  logic        write_back_stage;
  logic        rd_we;

  modport master (
    output stall, ir, rs1_data, rs2_data, pc,
    input  opcode, rd_sel, rs1_sel, rs2_sel, f3, f7, imm, len, illegal,
    input  alu_out, alu_zero, branch_taken, dest_reg_from, pc_load,
    input  dbus_re, dbus_we, load_ir, en_iaddr, en_pc_counter, write_back_stage, rd_we
  );

  modport slave (
    input  stall, ir, rs1_data, rs2_data, pc,
    output opcode, rd_sel, rs1_sel, rs2_sel, f3, f7, imm, len, illegal,
    output alu_out, alu_zero, branch_taken, dest_reg_from, pc_load,
    output dbus_re, dbus_we, load_ir, en_iaddr, en_pc_counter, write_back_stage, rd_we
  );

endinterface

// File: rtl/rv32i_decode_exec_alu.sv
// Integer ALU, purely combinational (0 cycles); no backpressure.
// Shifts use in_b[4:0]; all arithmetic wraps modulo 2^XLEN.
module rv_alu
  import rv32i_decode_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  alu_mode_t       mode,
  output logic [XLEN-1:0] out
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = in_b[4:0];
  assign lt_s  = $signed(in_a) < $signed(in_b);
  assign lt_u  = in_a < in_b;

  always_comb begin
    out = '0;
    case (mode)
      ALU_ADD:    out = in_a + in_b;
      ALU_SUB:    out = in_a - in_b;
      ALU_SLL:    out = in_a << shamt;
      ALU_SLT:    out = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:   out = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:    out = in_a ^ in_b;
      ALU_SRL:    out = in_a >> shamt;
      ALU_SRA:    out = $signed(in_a) >>> shamt;
      ALU_OR:     out = in_a | in_b;
      ALU_AND:    out = in_a & in_b;
      ALU_PASS_B: out = in_b;
      default:    out = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode_exec.sv
// RV32I decoder + FETCH/EXECUTE/WRITEBACK control FSM + ALU; decode and ALU are combinational,
// one instruction takes three unstalled cycles; stall freezes the FSM and holds the current strobes.
module rv32i_decode_exec
  import rv32i_decode_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                clk,
  input logic                rst,
  rv32i_decode_exec_if.slave bus
);

  logic [XLEN-1:0]   ir;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   imm_s;
  logic [XLEN-1:0]   imm_b;
  logic [XLEN-1:0]   imm_u;
  logic [XLEN-1:0]   imm_j;
  logic [XLEN-1:0]   imm;
  logic              illegal;
  logic              invert;
  alu_mode_t         mode;
  ins_ctrl_signals_t ctrl;

  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [XLEN-1:0]   alu_res;
  logic              alu_zero;

  state_t            state;
  state_t            state_nxt;
  logic              load_ir;
  logic              en_iaddr;
  logic              exec_stage;
  logic              en_pc_counter;
  logic              write_back_stage;

  assign ir  = bus.ir;
  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'h000};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    ctrl.alu_in_a      = SEL_A_RS1;
    ctrl.alu_in_b      = SEL_B_IMM;
    ctrl.dest_reg_from = DEST_NONE;
    ctrl.pc_load       = 1'b0;
    ctrl.branching     = 1'b0;
    ctrl.dbus_re       = 1'b0;
    ctrl.dbus_we       = 1'b0;
    imm                = '0;
    mode               = ALU_ADD;
    invert             = 1'b0;
    illegal            = 1'b0;
    case (opc)
      OPC_LUI: begin
        imm                = imm_u;
        mode               = ALU_PASS_B;
        ctrl.dest_reg_from = DEST_ALU;
      end
      OPC_AUIPC: begin
        imm                = imm_u;
        ctrl.alu_in_a      = SEL_A_PC;
        ctrl.dest_reg_from = DEST_ALU;
      end
      OPC_JAL: begin
        imm                = imm_j;
        ctrl.alu_in_a      = SEL_A_PC;
        ctrl.dest_reg_from = DEST_PC;
        ctrl.pc_load       = 1'b1;
      end
      OPC_JALR: begin
        imm                = imm_i;
        ctrl.dest_reg_from = DEST_PC;
        ctrl.pc_load       = 1'b1;
      end
      OPC_BRANCH: begin
        // Equality tests via SUB/zero, ordering via SLT(U); funct3[0] flips the sense.
        imm            = imm_b;
        ctrl.alu_in_b  = SEL_B_RS2;
        ctrl.branching = 1'b1;
        mode           = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        invert         = f3[2] ? f3[0] : ~f3[0];
      end
      OPC_LOAD: begin
        imm                = imm_i;
        ctrl.dest_reg_from = DEST_BUS;
        ctrl.dbus_re       = 1'b1;
      end
      OPC_STORE: begin
        imm          = imm_s;
        ctrl.dbus_we = 1'b1;
      end
      OPC_OPIMM: begin
        imm                = imm_i;
        mode               = op_mode(f3, (f3 == 3'd5) && f7[5]);
        ctrl.dest_reg_from = DEST_ALU;
      end
      OPC_OP: begin
        ctrl.alu_in_b      = SEL_B_RS2;
        mode               = op_mode(f3, f7[5]);
        ctrl.dest_reg_from = DEST_ALU;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_a = (ctrl.alu_in_a == SEL_A_PC)  ? bus.pc       : bus.rs1_data;
  assign alu_b = (ctrl.alu_in_b == SEL_B_RS2) ? bus.rs2_data : imm;

  rv_alu #(.XLEN(XLEN)) u_alu (
    .in_a (alu_a),
    .in_b (alu_b),
    .mode (mode),
    .out  (alu_res)
  );

  assign alu_zero = (alu_res == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    load_ir          = 1'b0;
    en_iaddr         = 1'b0;
    exec_stage       = 1'b0;
    en_pc_counter    = 1'b0;
    write_back_stage = 1'b0;
    case (state)
      ST_FETCH: begin
        load_ir  = 1'b1;
        en_iaddr = 1'b1;
        if (!bus.stall) state_nxt = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        exec_stage = 1'b1;
        if (!bus.stall) state_nxt = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        en_pc_counter    = 1'b1;
        write_back_stage = 1'b1;
        if (!bus.stall) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase
    // Every strobe below derives from these, so reset silences the whole block.
    if (rst) begin
      load_ir          = 1'b0;
      en_iaddr         = 1'b0;
      exec_stage       = 1'b0;
      en_pc_counter    = 1'b0;
      write_back_stage = 1'b0;
    end
  end

  assign bus.opcode           = opc;
  assign bus.rd_sel           = ir[11:7];
  assign bus.rs1_sel          = ir[19:15];
  assign bus.rs2_sel          = ir[24:20];
  assign bus.f3               = f3;
  assign bus.f7               = f7;
  assign bus.imm              = imm;
  assign bus.len              = (ir[1:0] == 2'b11) ? 32'd4 : 32'd2;
  assign bus.illegal          = illegal;
  assign bus.alu_out          = alu_res;
  assign bus.alu_zero         = alu_zero;
  assign bus.branch_taken     = ctrl.branching && (!alu_zero ^ invert);
  assign bus.dest_reg_from    = ctrl.dest_reg_from;
  assign bus.pc_load          = ctrl.pc_load && write_back_stage;
  assign bus.dbus_re          = ctrl.dbus_re && exec_stage;
  assign bus.dbus_we          = ctrl.dbus_we && exec_stage;
  assign bus.load_ir          = load_ir;
  assign bus.en_iaddr         = en_iaddr;
  assign bus.en_pc_counter    = en_pc_counter;
  assign bus.write_back_stage = write_back_stage;
  assign bus.rd_we            = write_back_stage && (ctrl.dest_reg_from != DEST_NONE)
                                && (ir[11:7] != 5'd0);

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Directed plus random bench for rv32i_decode_exec against an instruction-level reference model.
module tb_rv32i_decode_exec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   phase = 0;

  logic [6:0] opc_tab [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  logic [6:0] bad_tab [5] = '{7'h7F, 7'h0B, 7'h0F, 7'h73, 7'h5B};

  rv32i_decode_exec_if bus();

  rv32i_decode_exec #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] fn, input logic [31:0] x,
                                         input logic [31:0] y, input bit alt);
    int unsigned sh;
    sh = y & 32'd31;
    case (fn)
      3'd0:    return alt ? x - y : x + y;
      3'd1:    return x << sh;
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return alt ? 32'($signed(x) >>> sh) : x >> sh;
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [7:0] dut_strobes();
    return {bus.load_ir, bus.en_iaddr, bus.en_pc_counter, bus.write_back_stage,
            bus.dbus_re, bus.dbus_we, bus.rd_we, bus.pc_load};
  endfunction

  task automatic model_check();
    logic [31:0] i, a, b, e_imm, e_alu, e_len;
    logic [2:0]  fn;
    logic [7:0]  e_strb;
    int          e_dest;
    bit          e_ill, e_taken, e_jump, e_load, e_store;
    i = bus.ir; a = bus.rs1_data; b = bus.rs2_data; fn = i[14:12];
    e_imm = 0; e_alu = 0; e_dest = 0;
    e_ill = 0; e_taken = 0; e_jump = 0; e_load = 0; e_store = 0;
    case (i[6:0])
      7'h37: begin e_imm = i & 32'hFFFFF000; e_alu = e_imm; e_dest = 1; end
      7'h17: begin e_imm = i & 32'hFFFFF000; e_alu = bus.pc + e_imm; e_dest = 1; end
      7'h6F: begin
        e_imm = 32'((i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                    + int'(i[30:21]) * 2);
        e_alu = bus.pc + e_imm; e_dest = 3; e_jump = 1;
      end
      7'h67: begin e_imm = 32'($signed(i) >>> 20); e_alu = a + e_imm; e_dest = 3; e_jump = 1; end
      7'h63: begin
        e_imm = 32'((i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                    + int'(i[11:8]) * 2);
        case (fn)
          3'd0:    begin e_alu = a - b; e_taken = (a == b); end
          3'd1:    begin e_alu = a - b; e_taken = (a != b); end
          3'd4:    begin e_alu = ref_op(3'd2, a, b, 0); e_taken = ($signed(a) < $signed(b)); end
          3'd5:    begin e_alu = ref_op(3'd2, a, b, 0); e_taken = ($signed(a) >= $signed(b)); end
          3'd6:    begin e_alu = ref_op(3'd3, a, b, 0); e_taken = (a < b); end
          default: begin e_alu = ref_op(3'd3, a, b, 0); e_taken = (a >= b); end
        endcase
      end
      7'h03: begin e_imm = 32'($signed(i) >>> 20); e_alu = a + e_imm; e_dest = 2; e_load = 1; end
      7'h23: begin
        e_imm = 32'(($signed(i) >>> 25) * 32 + int'(i[11:7]));
        e_alu = a + e_imm; e_store = 1;
      end
      7'h13: begin
        e_imm = 32'($signed(i) >>> 20);
        e_alu = ref_op(fn, a, e_imm, (fn == 3'd5) && i[30]); e_dest = 1;
      end
      7'h33: begin e_alu = ref_op(fn, a, b, i[30]); e_dest = 1; end
      default: e_ill = 1;
    endcase
    e_len = (i[1:0] == 2'b11) ? 32'd4 : 32'd2;
    e_strb = '0;
    if (!rst) begin
      if (phase == 0) e_strb[7:6] = 2'b11;
      if (phase == 1) begin e_strb[3] = e_load; e_strb[2] = e_store; end
      if (phase == 2) begin
        e_strb[5:4] = 2'b11;
        e_strb[1]   = (e_dest != 0) && (i[11:7] != 5'd0);
        e_strb[0]   = e_jump;
      end
    end
    check("fields", {bus.f7, bus.rs2_sel, bus.rs1_sel, bus.f3, bus.rd_sel, bus.opcode}, i);
    check("imm", bus.imm, e_imm);
    check("len", bus.len, e_len);
    check("illegal", 32'(bus.illegal), 32'(e_ill));
    check("dest", 32'(bus.dest_reg_from), 32'(e_dest));
    check("branch_taken", 32'(bus.branch_taken), 32'(e_taken));
    check("strobes", 32'(dut_strobes()), 32'(e_strb));
    if (!e_ill) begin
      check("alu_out", bus.alu_out, e_alu);
      check("alu_zero", 32'(bus.alu_zero), 32'(e_alu == 32'd0));
    end
  endtask

  task automatic drive(input logic r, input logic s);
    @(negedge clk);
    rst = r;
    bus.stall = s;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) phase = 0;
    else if (!bus.stall) phase = (phase + 1) % 3;
    #1;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 40));
      1:       return 32'h80000000 | 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic new_instr();
    logic [31:0] i;
    int k;
    i = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) i[6:0] = opc_tab[k];
    else if (k == 9) i[1:0] = 2'($urandom_range(0, 2));
    else i[6:0] = bad_tab[$urandom_range(0, 4)];
    if (i[6:0] == 7'h63 && i[14:13] == 2'b01) i[14] = 1'b1;
    if ($urandom_range(0, 9) == 0) i[11:7] = 5'd0;
    bus.ir = i;
    bus.rs1_data = pick_val();
    bus.rs2_data = ($urandom_range(0, 3) == 0) ? bus.rs1_data : pick_val();
    bus.pc = $urandom & 32'hFFFFFFFC;
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.ir = 32'h00000013;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    bus.pc = 32'd0;

    // reset, including reset together with stall
    drive(1'b1, 1'b0);
    check("rst_strobes", 32'(dut_strobes()), 32'd0);
    tick();
    drive(1'b1, 1'b1);
    check("rst_stall_strobes", 32'(dut_strobes()), 32'd0);
    tick();

    // addi x1,x0,5
    bus.ir = 32'h00500093;
    drive(1'b0, 1'b0);
    check("addi_imm", bus.imm, 32'd5);
    check("addi_rd", 32'(bus.rd_sel), 32'd1);
    check("addi_alu", bus.alu_out, 32'd5);
    check("addi_dest", 32'(bus.dest_reg_from), 32'd1);
    check("addi_fetch_load_ir", 32'(bus.load_ir), 32'd1);
    check("addi_fetch_rd_we", 32'(bus.rd_we), 32'd0);
    tick();
    drive(1'b0, 1'b0);
    check("addi_exec_rd_we", 32'(bus.rd_we), 32'd0);
    tick();
    drive(1'b0, 1'b0);
    check("addi_wb_rd_we", 32'(bus.rd_we), 32'd1);
    tick();

    // sra then srl
    bus.ir = 32'h40315233; bus.rs1_data = 32'h80000000; bus.rs2_data = 32'd4;
    drive(1'b0, 1'b0);
    check("sra_alu", bus.alu_out, 32'hF8000000);
    tick();
    bus.ir = 32'h00315233;
    drive(1'b0, 1'b0);
    check("srl_alu", bus.alu_out, 32'h08000000);
    tick();
    drive(1'b0, 1'b0);
    tick();

    // beq x1,x2,-4
    bus.ir = 32'hFE208EE3; bus.rs1_data = 32'd7; bus.rs2_data = 32'd7;
    drive(1'b0, 1'b0);
    check("beq_imm", bus.imm, 32'hFFFFFFFC);
    check("beq_taken", 32'(bus.branch_taken), 32'd1);
    tick();
    bus.rs2_data = 32'd8;
    drive(1'b0, 1'b0);
    check("beq_not_taken", 32'(bus.branch_taken), 32'd0);
    tick();
    drive(1'b0, 1'b0);
    check("beq_wb_rd_we", 32'(bus.rd_we), 32'd0);
    tick();

    // lw x3,4(x1) with three stalled EXECUTE cycles
    bus.ir = 32'h0040A183; bus.rs1_data = 32'h100;
    drive(1'b0, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, c < 3);
      check("lw_dbus_re", 32'(bus.dbus_re), 32'd1);
      check("lw_alu", bus.alu_out, 32'h104);
      tick();
    end
    drive(1'b0, 1'b0);
    check("lw_wb_stage", 32'(bus.write_back_stage), 32'd1);
    check("lw_dest", 32'(bus.dest_reg_from), 32'd2);
    tick();

    // jal x1,8
    bus.ir = 32'h008000EF; bus.pc = 32'h20;
    drive(1'b0, 1'b0);
    check("jal_alu", bus.alu_out, 32'h28);
    check("jal_dest", 32'(bus.dest_reg_from), 32'd3);
    check("jal_fetch_pc_load", 32'(bus.pc_load), 32'd0);
    tick();
    drive(1'b0, 1'b0);
    check("jal_exec_pc_load", 32'(bus.pc_load), 32'd0);
    tick();
    drive(1'b0, 1'b0);
    check("jal_wb_pc_load", 32'(bus.pc_load), 32'd1);
    tick();

    // reset during EXECUTE of a store abandons it
    bus.ir = 32'h0020A023;
    drive(1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0);
    check("rst_exec_strobes", 32'(dut_strobes()), 32'd0);
    tick();
    drive(1'b0, 1'b0);
    check("after_rst_fetch", 32'(bus.load_ir), 32'd1);
    tick();
    drive(1'b0, 1'b0);
    check("sw_dbus_we", 32'(bus.dbus_we), 32'd1);
    tick();
    drive(1'b0, 1'b0);
    tick();

    // unsupported opcode still sequences but requests nothing
    bus.ir = 32'h0000007F;
    drive(1'b0, 1'b0);
    check("ill_flag", 32'(bus.illegal), 32'd1);
    tick();
    drive(1'b0, 1'b0);
    check("ill_bus", {30'd0, bus.dbus_re, bus.dbus_we}, 32'd0);
    tick();
    drive(1'b0, 1'b0);
    check("ill_rd_we", 32'(bus.rd_we), 32'd0);
    check("ill_pc_adv", 32'(bus.en_pc_counter), 32'd1);
    tick();

    for (int n = 0; n < 600; n++) begin
      if (phase == 0) new_instr();
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_exec.md
Name: rv32i_decode_exec

Overview:
- Combined RV32I instruction decoder, multi-cycle control FSM and integer ALU for the CPU core.
- Takes the instruction register, register-file read data and current PC.
- Produces register selects, immediate, datapath steering, bus strobes, ALU result and branch decision.
- Register file, PC, memory unit and bus adapters are external.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  hold FSM in current state (bus wait)
- ir  in  32  current instruction
- rs1_data  in  32  register file rs1 value
- rs2_data  in  32  register file rs2 value
- pc  in  32  address of current instruction
- opcode  out  7  ir[6:0]
- rd_sel, rs1_sel, rs2_sel  out  5 each  ir[11:7], ir[19:15], ir[24:20]
- f3  out  3  ir[14:12]
- f7  out  7  ir[31:25]
- imm  out  32  sign-extended immediate
- len  out  32  instruction length in bytes
- illegal  out  1  unsupported opcode
- alu_out  out  32  ALU result
- alu_zero  out  1  alu_out == 0
- branch_taken  out  1  select imm as PC step
- dest_reg_from  out  2  0 NONE, 1 ALU, 2 BUS, 3 PC (return address)
- pc_load  out  1  load PC from alu_out
- dbus_re, dbus_we  out  1 each  data bus read/write request
- load_ir, en_iaddr, en_pc_counter, write_back_stage  out  1 each  FSM strobes
- rd_we  out  1  register write enable

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Decoder (combinational):
  - imm per format: I (LOAD, OP-IMM, JALR), S, B, U (LUI, AUIPC), J; 0 for other opcodes.
  - len = 4 when ir[1:0] == 2'b11, else 2 with illegal = 1.
  - illegal = 1 for any opcode outside LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Operand A = pc for AUIPC and JAL, else rs1_data.
- Operand B = rs2_data for OP and BRANCH, else imm.
- ALU modes: ADD, SUB, SLL, SLT (signed), SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
  - Shift amount is in_b[4:0]; SRA is arithmetic; wrap-around modulo 2^32.
- Mode select:
  - OP: by f3; f7[5] selects SUB (f3=0) or SRA (f3=5).
  - OP-IMM: by f3; f7[5] selects SRAI only for f3=5; f3=0 is always ADD.
  - LUI: PASS_B.
  - AUIPC, JAL, JALR, LOAD, STORE: ADD.
- Branch compare and invert:
  - BEQ: SUB, invert=1. BNE: SUB, invert=0.
  - BLT: SLT, invert=0. BGE: SLT, invert=1.
  - BLTU: SLTU, invert=0. BGEU: SLTU, invert=1.
  - branch_taken = BRANCH opcode && (!alu_zero XOR invert).
- dest_reg_from: ALU for LUI, AUIPC, OP, OP-IMM; BUS for LOAD; PC for JAL/JALR; NONE for BRANCH, STORE, illegal.
- pc_load = (JAL or JALR) && write_back_stage. The PC unit clears bit 0 of the JALR target.
- FSM states FETCH, EXECUTE, WRITEBACK; each state advances only when stall == 0.
  - FETCH: en_iaddr = 1, load_ir = 1; goes to EXECUTE.
  - EXECUTE: dbus_re = LOAD, dbus_we = STORE; goes to WRITEBACK.
  - WRITEBACK: write_back_stage = 1, en_pc_counter = 1; goes to FETCH.
- rd_we = write_back_stage && dest_reg_from != NONE && rd_sel != 0.
- Illegal instruction: no rd_we, no bus strobes, no pc_load; the PC still advances.
- Reset:
  - rst high at a rising edge forces FETCH.
  - While rst is high, all strobes are 0 (load_ir, en_iaddr, en_pc_counter, write_back_stage, dbus_re, dbus_we, rd_we, pc_load).
  - Reset mid-instruction abandons the instruction.
- stall and rst together: rst wins.

Decomposition:
- Shared package holds:
  - alu_mode_t
  - dest_reg_from_t (NONE/ALU/BUS/PC)
  - opcode constants
  - FSM state enum
  - ins_ctrl_signals_t struct (alu_in_a, alu_in_b, dest_reg_from, pc_load, branching, dbus_re, dbus_we)
- One sub-module: rv_alu (in_a, in_b, mode -> out).
- Decoder and FSM stay in the top module.

Test Plan:
- ir=0x00500093 (addi x1,x0,5), rs1_data=0 -> imm=5, rd_sel=1, alu_out=5, dest=ALU; rd_we=1 only in WRITEBACK, after 2 cycles from FETCH with stall=0.
- ir=0x40315233 (sra x4,x2,x3), rs1_data=0x80000000, rs2_data=4 -> alu_out=0xF8000000; with f7[5]=0 (srl) -> 0x08000000.
- ir=0xFE208EE3 (beq x1,x2,-4), rs1_data=rs2_data=7 -> imm=0xFFFFFFFC, branch_taken=1; rs2_data=8 -> branch_taken=0, rd_we never asserted.
- ir=0x0040A183 (lw x3,4(x1)), rs1_data=0x100, stall=1 for 3 cycles in EXECUTE -> dbus_re held 4 cycles, alu_out=0x104, then WRITEBACK with dest=BUS.
- ir=0x008000EF (jal x1,8), pc=0x20 -> alu_out=0x28, dest=PC, pc_load=1 in WRITEBACK only.
- rst=1 asserted during EXECUTE -> next cycle state FETCH, all strobes 0 while rst high; ir=0x0000007F -> illegal=1, rd_we=0, dbus_re=dbus_we=0.
